// File: rtl/rpn_calculator.sv
// rtl/rpn_calculator.sv - postfix calculator core with LIFO operand stack; optional divider enabled by RPN_DIV_EN
module rpn_calculator #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       input_stb,
    input  logic [WIDTH-1:0]           input_data,
    input  logic                       is_input_operator,
    output logic                       input_ack,
    output logic                       output_stb,
    output logic [WIDTH-1:0]           output_data,
    output logic [1:0]                 output_err,
    input  logic                       output_ack,
    output logic [$clog2(DEPTH+1)-1:0] stack_depth
);
    localparam int DW    = $clog2(DEPTH + 1);
    localparam int AW    = $clog2(DEPTH);
    localparam int SLOTS = 1 << AW;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PUSH = 3'd1;
    localparam logic [2:0] S_EXEC = 3'd2;
    localparam logic [2:0] S_DIV  = 3'd3;
    localparam logic [2:0] S_EMIT = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;
    localparam logic [2:0] S_ACK  = 3'd6;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_EMIT = 3'b100;
    localparam logic [2:0] OP_CLR  = 3'b101;

    localparam logic [1:0] E_UNDER = 2'b01;
    localparam logic [1:0] E_OVER  = 2'b10;
    localparam logic [1:0] E_ILL   = 2'b11;

    logic [2:0]       state_q, state_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       err_q, err_d;

    logic [WIDTH-1:0] stack_mem [SLOTS];
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_data;

    logic [AW-1:0]    top_idx, second_idx;
    logic [WIDTH-1:0] top, second;
    logic [WIDTH-1:0] alu_result;

    assign top_idx    = AW'(depth_q - DW'(1));
    assign second_idx = AW'(depth_q - DW'(2));
    assign top        = stack_mem[top_idx];
    assign second     = stack_mem[second_idx];

`ifdef RPN_DIV_EN
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_shift, rem_diff;
    logic             rem_fits;

    // One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, top};
        rem_fits  = (rem_shift >= {1'b0, top});
    end
`endif

    // Result of the two-operand operators; second is the deeper entry, top the most recent
    always_comb begin
        alu_result = '0;
        case (op_q)
            OP_ADD:  alu_result = second + top;
            OP_SUB:  alu_result = second - top;
            OP_MUL:  alu_result = second * top;
`ifdef RPN_DIV_EN
            OP_DIV:  alu_result = quo_q;
`endif
            default: alu_result = '0;
        endcase
    end

    // Token dispatch and sequencing; all depth checks happen before the stack is touched
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        op_d    = op_q;
        data_d  = data_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_idx  = top_idx;
        wr_data = alu_result;
`ifdef RPN_DIV_EN
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (input_stb) begin
                    data_d = input_data;
                    op_d   = input_data[2:0];
                    if (!is_input_operator) begin
                        if (depth_q == DW'(DEPTH)) begin
                            err_d   = E_OVER;
                            depth_d = '0;
                            state_d = S_ERR;
                        end else begin
                            state_d = S_PUSH;
                        end
                    end else begin
                        case (input_data[2:0])
                            OP_ADD, OP_SUB, OP_MUL: begin
                                if (depth_q < DW'(2)) begin
                                    err_d   = E_UNDER;
                                    depth_d = '0;
                                    state_d = S_ERR;
                                end else begin
                                    state_d = S_EXEC;
                                end
                            end
                            OP_DIV: begin
`ifdef RPN_DIV_EN
                                if (depth_q < DW'(2)) begin
                                    err_d   = E_UNDER;
                                    depth_d = '0;
                                    state_d = S_ERR;
                                end else if (top == '0) begin
                                    err_d   = E_ILL;
                                    depth_d = '0;
                                    state_d = S_ERR;
                                end else begin
                                    quo_d   = second;
                                    rem_d   = '0;
                                    cnt_d   = '0;
                                    state_d = S_DIV;
                                end
`else
                                err_d   = E_ILL;
                                depth_d = '0;
                                state_d = S_ERR;
`endif
                            end
                            OP_EMIT: begin
                                if (depth_q == '0) begin
                                    err_d   = E_UNDER;
                                    depth_d = '0;
                                    state_d = S_ERR;
                                end else begin
                                    state_d = S_EMIT;
                                end
                            end
                            OP_CLR: begin
                                depth_d = '0;
                                state_d = S_ACK;
                            end
                            default: begin
                                err_d   = E_ILL;
                                depth_d = '0;
                                state_d = S_ERR;
                            end
                        endcase
                    end
                end
            end
            S_PUSH: begin
                wr_en   = 1'b1;
                wr_idx  = AW'(depth_q);
                wr_data = data_q;
                depth_d = depth_q + DW'(1);
                state_d = S_ACK;
            end
            S_EXEC: begin
                wr_en   = 1'b1;
                wr_idx  = second_idx;
                wr_data = alu_result;
                depth_d = depth_q - DW'(1);
                state_d = S_ACK;
            end
            S_DIV: begin
`ifdef RPN_DIV_EN
                if (rem_fits) begin
                    rem_d = rem_diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_EXEC;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_EMIT: begin
                if (output_ack) begin
                    depth_d = depth_q - DW'(1);
                    state_d = S_ACK;
                end
            end
            S_ERR: begin
                if (output_ack) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state; reset abandons any token in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            depth_q <= '0;
            op_q    <= '0;
            data_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            op_q    <= op_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

`ifdef RPN_DIV_EN
    // Divider working registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            quo_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
        end
    end
`endif

    // Stack storage; contents are meaningless above the current depth
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            stack_mem[wr_idx] <= wr_data;
        end
    end

    assign input_ack   = (state_q == S_ACK);
    assign output_stb  = (state_q == S_EMIT) || (state_q == S_ERR);
    assign output_data = (state_q == S_EMIT) ? top : '0;
    assign output_err  = (state_q == S_ERR) ? err_q : 2'b00;
    assign stack_depth = depth_q;

endmodule

// File: doc/rpn_calculator.md
# rpn_calculator

Parametrised postfix-notation (RPN) calculator core: the next-generation replacement for the fixed 32-bit calculator. Operands and operators arrive as a token stream on a strobe/ack handshake. Operands go onto an internal LIFO of configurable width and depth. Operators pop two entries and push the result back. An emit operator returns the top of stack on a strobe/ack output channel. It adds the error detection (underflow, overflow, illegal opcode) and stack-depth reporting the old block lacked, and sits between the token parser and the result formatter.

## Interface
- WIDTH, 32: operand, stack-entry and result width in bits (>= 4).
- DEPTH, 16: stack entries (>= 2).
- CLK  in  1  rising-edge clock; one clock; reset is synchronous and active-high.
- RST  in  1  synchronous active-high reset.
- input_stb  in  1  token valid; held with data stable until input_ack.
- input_data  in  WIDTH  operand, or opcode in [2:0] when operator.
- is_input_operator  in  1  1 = input_data is an opcode.
- input_ack  out  1  one-cycle pulse: token consumed.
- output_stb  out  1  result/error valid; held until output_ack.
- output_data  out  WIDTH  emitted value (0 on error).
- output_err  out  2  00 ok, 01 underflow, 10 overflow, 11 illegal op / divide-by-zero.
- output_ack  in  1  consumer accepts result.
- stack_depth  out  clog2(DEPTH+1)  current entry count.

## Operation
- Opcodes: 000 add; 001 sub (second minus top); 010 mul (low WIDTH bits); 011 div (macro only); 100 emit (pop top, output it); 101 clear (depth := 0, no output); 110/111 illegal.
- Arithmetic is unsigned and wraps modulo 2^WIDTH; no carry or overflow flag.
- FSM states: IDLE, PUSH, EXEC, DIV, EMIT, ERR, ACK.
- IDLE: samples input_stb. Operand -> PUSH; opcode 000-011 -> EXEC (or DIV); 100 -> EMIT; 101 -> ACK with clear. Illegal opcode, or a depth check failure, -> ERR.
- Depth checks happen in IDLE, before the stack is touched:
  - push with depth == DEPTH -> overflow;
  - binary op with depth < 2 -> underflow;
  - emit with depth == 0 -> underflow.
- PUSH writes the operand, depth+1, -> ACK. EXEC replaces the top two entries with the result, depth-1, -> ACK.
- EMIT: output_stb=1, output_data=top, output_err=00, and holds while output_ack=0. Once output_ack is seen: depth-1, output_stb drops -> ACK.
- ERR: output_stb=1, output_err=code, output_data=0. The stack is cleared (depth := 0) on entry. Waits for output_ack -> ACK.
- ACK: input_ack=1 for exactly one cycle -> IDLE.
- input_stb is ignored in every state except IDLE.
- Reset mid-operation: the token in flight is discarded with no input_ack. The consumer must tolerate output_stb dropping without an ack.
- Reset values: depth 0, state IDLE, and all outputs 0 (input_ack, output_stb, output_data, output_err, stack_depth). Stack RAM contents are don't-care.

## Timing
- T = cycle in IDLE where input_stb=1 is sampled.
- Push: write at T+1, input_ack at T+2. Back-to-back pushes sustain one token per 3 cycles.
- add/sub/mul: result written at T+1, input_ack at T+2. Multiply is single-cycle combinational.
- div: quotient written at T+WIDTH+1, input_ack at T+WIDTH+2.
- Emit/error: output_stb rises at T+1. If output_ack is high in cycle k, output_stb is low at k+1 and input_ack pulses at k+1.
- output_data and output_err are stable while output_stb=1.
- stack_depth updates in the cycle after the write/pop edge.

## Configuration
- RPN_DIV_EN defined: opcode 011 enables an iterative restoring unsigned divider, WIDTH cycles long (second / top; quotient pushed, remainder dropped). A zero divisor is detected in IDLE and raises error 11; the operands are lost with the cleared stack.
- RPN_DIV_EN undefined: opcode 011 is illegal (error 11) and no divider logic is synthesised.

## Test plan
- WIDTH=32: push 3, push 4, add, emit -> output_data=7, err=00, depth 0; input_ack at T+2 for each push.
- Push 10, push 2, sub, emit -> 8. Push 2, push 10, sub, emit -> 0xFFFFFFF8 (wrap).
- WIDTH=8: push 20, push 20, mul, emit -> 144 (400 mod 256).
- Push 5, add -> output_err=01, output_data=0, depth 0. After output_ack, input_ack pulses and the next push is accepted normally.
- DEPTH=4: push 1..4, then push 5 -> err=10, depth 0. Assert RST during a held output_stb -> next cycle output_stb=0 and depth=0.
- With RPN_DIV_EN: push 100, push 7, div, emit -> 14, with input_ack at T+WIDTH+2; push 1, push 0, div -> err=11. Without the macro: opcode 011 -> err=11.
